host_uart_rx: RTL and testbench

HOST_UART_RX -- requirements
Module: host_uart_rx

---
 rtl/host_uart_rx.sv | 222 ++++++++++++++++++++++
 tb/tb_host_uart_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/host_uart_rx.sv
// ----------------------------------------------------------------------------
// host_uart_rx
//   8N1 serial receiver with a small byte FIFO and a load-session tracker.
//   The line is resynchronised, each frame is sampled mid-bit, and good bytes
//   are queued for a consumer. done_o reports whether a load session is still
//   in progress (bytes arriving or waiting in the FIFO).
//
// Parameters
//   CLKS_PER_BIT : clk_i cycles per serial bit (even, >= 4)
//   FIFO_DEPTH   : receive FIFO entries (power of two, >= 2)
//   IDLE_BITS    : bit-times of idle line that end a load session
//
// Ports
//   clk_i        in   single clock, rising edge
//   rst_i        in   synchronous reset, active low
//   rx_i         in   asynchronous serial line, idle high, LSB first
//   data_o       out  byte at FIFO head (0 while the FIFO is empty)
//   valid_o      out  FIFO not empty
//   ack_i        in   pop strobe, honoured only while valid_o = 1
//   done_o       out  1 = no load session in progress
//   frame_err_o  out  one-cycle pulse: stop bit sampled low
//   overrun_o    out  one-cycle pulse: good byte dropped on a full FIFO
// ----------------------------------------------------------------------------
module host_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned IDLE_BITS    = 20
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ack_i,
  output logic       done_o,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int unsigned CNT_W      = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W      = PTR_W + 1;
  localparam int unsigned IDLE_LIMIT = IDLE_BITS * CLKS_PER_BIT;
  localparam int unsigned TMR_W      = $clog2(IDLE_LIMIT + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
  localparam logic [TMR_W-1:0] TMR_SAT  = TMR_W'(IDLE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic             rx_meta_q, rx_sync_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             done_q, done_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic [7:0]       mem_q [FIFO_DEPTH];

  logic push_req;   // stop bit good: byte in shift_q wants to enter the FIFO
  logic start_ok;   // start bit confirmed at mid-bit
  logic pop;
  logic full;
  logic accept;     // push actually written into the FIFO

  // --------------------------------------------------------------------------
  // Receive FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    shift_d     = shift_q;
    push_req    = 1'b0;
    frame_err_d = 1'b0;
    start_ok    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_sync_q) state_d = S_START;
      end
      S_START: begin
        // A low that has vanished by mid-bit is a glitch: drop it silently.
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_sync_q) begin
            state_d  = S_DATA;
            idx_d    = '0;
            start_ok = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_sync_q;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        // Return to IDLE on the sample cycle itself so a back-to-back start
        // edge is seen on the very next cycle.
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rx_sync_q) push_req    = 1'b1;
          else           frame_err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FIFO control
  // --------------------------------------------------------------------------
  always_comb begin
    pop       = valid_o & ack_i;
    full      = (occ_q == OCC_FULL);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    accept    = push_req & (~full | pop);
    overrun_d = push_req & full & ~pop;

    wr_ptr_d  = accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop    ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    unique case ({accept, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Idle timer and session flag
  // --------------------------------------------------------------------------
  always_comb begin
    timer_d = '0;
    if (state_q == S_IDLE && rx_sync_q) begin
      timer_d = (timer_q == TMR_SAT) ? timer_q : timer_q + TMR_W'(1);
    end

    done_d = done_q;
    if (start_ok) begin
      done_d = 1'b0;
    end else if (timer_q == TMR_SAT && occ_q == '0) begin
      done_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      timer_q     <= '0;
      done_q      <= 1'b1;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx_i;
      rx_sync_q   <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      timer_q     <= timer_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // NOTE: the storage array has no reset; its contents are never visible
  // while occ_q = 0 because data_o is gated by valid_o below.
  always_ff @(posedge clk_i) begin
    if (accept) mem_q[wr_ptr_q] <= shift_q;
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign valid_o     = (occ_q != '0);
  assign data_o      = valid_o ? mem_q[rd_ptr_q] : 8'h00;
  assign done_o      = done_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_host_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_host_uart_rx
//   Directed bench for host_uart_rx at CLKS_PER_BIT=16, FIFO_DEPTH=4,
//   IDLE_BITS=20. A frame is driven as 160 cycles: start bit in frame cycles
//   0..15, data bit i in 16+16i..31+16i, stop bit in 144..159. With the two
//   flop synchroniser the start bit is confirmed in the cycle after edge 10,
//   and the stop bit is sampled in the cycle after edge 154, so a good byte
//   is visible on valid_o from frame cycle 155.
// ----------------------------------------------------------------------------
module tb_host_uart_rx;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       rx_i  = 1'b1;
  logic       ack_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o;
  logic       done_o;
  logic       frame_err_o;
  logic       overrun_o;

  host_uart_rx #(
    .CLKS_PER_BIT(16),
    .FIFO_DEPTH  (4),
    .IDLE_BITS   (20)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rx_i       (rx_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ack_i      (ack_i),
    .done_o     (done_o),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_fe;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drive one 160-cycle frame; optionally pulse ack_i in frame cycle ack_at.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int ack_at,
                            output int valid_c, output int fe_hits, output int ov_hits,
                            output logic done10, output logic done11);
    valid_c = -1;
    fe_hits = 0;
    ov_hits = 0;
    done10  = 1'bx;
    done11  = 1'bx;
    for (int c = 0; c < 160; c++) begin
      tick();
      if (c < 16)       rx_i = 1'b0;
      else if (c < 144) rx_i = b[(c - 16) / 16];
      else              rx_i = stop;
      ack_i = (c == ack_at);
      if (valid_o && valid_c < 0) valid_c = c;
      if (frame_err_o) fe_hits++;
      if (overrun_o)   ov_hits++;
      if (c == 10) done10 = done_o;
      if (c == 11) done11 = done_o;
    end
    ack_i = 1'b0;
    rx_i  = 1'b1;
  endtask

  task automatic pop_expect(input string name, input logic [7:0] exp);
    check({name, ".valid"}, valid_o, 1'b1);
    check({name, ".data"}, data_o, exp);
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
  endtask

  vec_t vecs [6];
  int   valid_c, fe_hits, ov_hits, ov_total, fe_sum, v_seen, d_low, cyc_end, rise;
  logic done10, done11;

  initial begin
    vecs[0] = '{data: 8'h3C, stop: 1'b0, exp_valid: 1'b0, exp_data: 8'h00, exp_fe: 1};
    vecs[1] = '{data: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h00, exp_fe: 0};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'hFF, exp_fe: 0};
    vecs[3] = '{data: 8'h81, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h81, exp_fe: 0};
    vecs[4] = '{data: 8'h7E, stop: 1'b0, exp_valid: 1'b0, exp_data: 8'h00, exp_fe: 1};
    vecs[5] = '{data: 8'h96, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h96, exp_fe: 0};

    // ---- reset values ----
    idle(3);
    check("rst.valid", valid_o, 1'b0);
    check("rst.data", data_o, 8'h00);
    check("rst.done", done_o, 1'b1);
    check("rst.frame_err", frame_err_o, 1'b0);
    check("rst.overrun", overrun_o, 1'b0);
    rst_i = 1'b1;
    idle(5);

    // ---- glitch rejection: 3-cycle low pulse ----
    rx_i = 1'b0;
    idle(3);
    rx_i = 1'b1;
    fe_sum = 0; v_seen = 0; d_low = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (frame_err_o) fe_sum++;
      if (valid_o)     v_seen++;
      if (!done_o)     d_low++;
    end
    check("glitch.frame_err", fe_sum, 0);
    check("glitch.valid", v_seen, 0);
    check("glitch.done_low", d_low, 0);

    // ---- 0xA5, good stop ----
    send_frame(8'hA5, 1'b1, -1, valid_c, fe_hits, ov_hits, done10, done11);
    check("a5.done_before_start_ok", done10, 1'b1);
    check("a5.done_after_start_ok", done11, 1'b0);
    check("a5.valid_cycle", valid_c, 155);
    check("a5.frame_err", fe_hits, 0);
    pop_expect("a5.pop", 8'hA5);
    check("a5.valid_after_ack", valid_o, 1'b0);
    ack_i = 1'b1;             // ack while empty must be ignored
    tick();
    ack_i = 1'b0;
    check("a5.ack_empty", valid_o, 1'b0);
    idle(20);

    // ---- table of frames ----
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].data, vecs[v].stop, -1, valid_c, fe_hits, ov_hits, done10, done11);
      idle(20);
      check($sformatf("vec%0d.frame_err", v), fe_hits, vecs[v].exp_fe);
      check($sformatf("vec%0d.overrun", v), ov_hits, 0);
      check($sformatf("vec%0d.valid", v), valid_o, vecs[v].exp_valid);
      if (vecs[v].exp_valid) begin
        check($sformatf("vec%0d.valid_cycle", v), valid_c, 155);
        pop_expect($sformatf("vec%0d.pop", v), vecs[v].exp_data);
        check($sformatf("vec%0d.empty", v), valid_o, 1'b0);
      end
    end

    // ---- overrun: five back-to-back bytes, no acks ----
    ov_total = 0;
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 1'b1, -1, valid_c, fe_hits, ov_hits, done10, done11);
      ov_total += ov_hits;
      if (k == 5) check("ovr.pulse_on_5th", ov_hits, 1);
    end
    cyc_end = cyc;
    check("ovr.total", ov_total, 1);
    for (int k = 1; k <= 4; k++) pop_expect($sformatf("ovr.pop%0d", k), 8'(k));
    check("ovr.empty", valid_o, 1'b0);
    rise = -1;
    for (int i = 0; i < 400 && rise < 0; i++) begin
      if (done_o) rise = cyc - cyc_end;
      else tick();
    end
    // Timer counts edges 156..475 after the last start; done_o follows at 476.
    check("ovr.done_rise_window", (rise >= 316 && rise <= 318), 1'b1);
    idle(10);

    // ---- full FIFO, push and pop in the same cycle ----
    ov_total = 0;
    for (int k = 0; k < 4; k++) begin
      send_frame(8'h10 + 8'(k), 1'b1, -1, valid_c, fe_hits, ov_hits, done10, done11);
      ov_total += ov_hits;
    end
    send_frame(8'h14, 1'b1, 154, valid_c, fe_hits, ov_hits, done10, done11);
    ov_total += ov_hits;
    check("full.no_overrun", ov_total, 0);
    for (int k = 1; k <= 4; k++) pop_expect($sformatf("full.pop%0d", k), 8'h10 + 8'(k));
    check("full.empty", valid_o, 1'b0);
    idle(20);

    // ---- reset in the middle of a frame ----
    send_frame(8'h77, 1'b1, -1, valid_c, fe_hits, ov_hits, done10, done11);
    check("rstmid.prefill", valid_o, 1'b1);
    rx_i = 1'b0;
    idle(16);
    rx_i = 1'b1;               // data bits of 0xFF
    idle(40);
    rst_i = 1'b0;
    idle(2);
    check("rstmid.valid", valid_o, 1'b0);
    check("rstmid.data", data_o, 8'h00);
    check("rstmid.done", done_o, 1'b1);
    check("rstmid.frame_err", frame_err_o, 1'b0);
    check("rstmid.overrun", overrun_o, 1'b0);
    idle(2);
    rst_i = 1'b1;
    v_seen = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (valid_o) v_seen++;
    end
    check("rstmid.no_partial", v_seen, 0);
    send_frame(8'h5A, 1'b1, -1, valid_c, fe_hits, ov_hits, done10, done11);
    check("rstmid.5a_cycle", valid_c, 155);
    pop_expect("rstmid.pop", 8'h5A);
    check("rstmid.empty", valid_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
